mmio_input_port: RTL and testbench

- Memory-mapped input peripheral on the CPU data bus (mem_cmd / mem_addr / write_data / read_data), in parallel with RAM and the LED register.
- Conditions raw switch inputs: 2-flop synchroniser, then per-bit debounce.
- Exposes the debounced level, a sticky rising-edge capture register and an interrupt mask.
- Drives read_data only when addressed; top level muxes read_data using read_en.

---
 rtl/mmio_input_port_pkg.sv | 30 +++
 rtl/mmio_input_port_input_debounce.sv | 65 ++++++
 rtl/mmio_input_port.sv | 170 +++++++++++++++++
 tb/tb_mmio_input_port.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_input_port_pkg
// Description : Bus command encodings, register offsets and default base
//               addresses shared by the memory-mapped input port.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_input_port_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [1:0] OFF_LEVEL = 2'd0;
    localparam logic [1:0] OFF_EDGE  = 2'd1;
    localparam logic [1:0] OFF_MASK  = 2'd2;
    localparam logic [1:0] OFF_FALL  = 2'd3;

    localparam logic [8:0] SW_BASE_ADDR  = 9'h140;
    localparam logic [8:0] LED_BASE_ADDR = 9'h100;

    // True when a register offset decodes to an implemented register.
    function automatic logic reg_mapped(input logic [1:0] off, input logic fall_en);
        return (off != OFF_FALL) || fall_en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_input_port_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : One input bit: two-flop synchroniser followed by a counter
//               that accepts a new level after DB_CYCLES stable samples.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int                 c_CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q;
    logic               stable_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               w_accept;

    // Counter only runs while the synchronised level disagrees with stable,
    // so it saturates at the accept point and can never wrap.
    always_comb begin
        w_accept = 1'b0;
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == c_CNT_MAX) begin
                w_accept = 1'b1;
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = w_accept &  sync2_q;
    assign fall   = w_accept & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/mmio_input_port.sv
`default_nettype none
// ============================================================================
// Module      : mmio_input_port
// Description : Memory-mapped switch input port: debounced level, sticky
//               rising-edge register with read-clear, interrupt mask and irq.
//               Define MMIO_FALL_EDGE_EN to add the falling-edge register.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_input_port
    import mmio_input_port_pkg::*;
#(
    parameter int         WIDTH     = 10,
    parameter int         DB_CYCLES = 50000,
    parameter logic [8:0] BASE_ADDR = SW_BASE_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic [1:0]       mem_cmd,
    input  logic [8:0]       mem_addr,
    input  logic [15:0]      write_data,
    output logic [15:0]      read_data,
    output logic             read_en,
    output logic             irq
);

`ifdef MMIO_FALL_EDGE_EN
    localparam logic c_FALL_EN = 1'b1;
`else
    localparam logic c_FALL_EN = 1'b0;
`endif

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        input_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .sw_raw (sw_raw[i]),
            .stable (w_stable[i]),
            .rise   (w_rise[i]),
            .fall   (w_fall[i])
        );
    end

    // Address decode relative to BASE_ADDR (need not be 4-aligned).
    logic [8:0] w_delta;
    logic [1:0] w_off;
    logic       w_in_range;
    logic       w_wr;
    logic       w_edge_rd;

    assign w_delta    = mem_addr - BASE_ADDR;
    assign w_off      = w_delta[1:0];
    assign w_in_range = (w_delta[8:2] == 7'd0);
    assign read_en    = (mem_cmd == MREAD) && w_in_range && reg_mapped(w_off, c_FALL_EN);
    assign w_wr       = (mem_cmd == MWRITE) && w_in_range;
    assign w_edge_rd  = read_en && (w_off == OFF_EDGE);

    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             rd_active_q, rd_active_d;
    logic             irq_q, irq_d;

`ifdef MMIO_FALL_EDGE_EN
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] fall_snap_q, fall_snap_d;
    logic             fall_rd_active_q, fall_rd_active_d;
    logic             w_fall_rd;
    logic             w_unused;

    assign w_fall_rd = read_en && (w_off == OFF_FALL);
    assign w_unused  = ^write_data;
`else
    logic w_unused;

    assign w_unused = ^{write_data, w_fall};
`endif

    // Clears (read or W1C) are applied before new edges so set always wins.
    always_comb begin
        edge_d      = edge_q;
        snap_d      = snap_q;
        rd_active_d = w_edge_rd;
        if (w_edge_rd && !rd_active_q) begin
            snap_d = edge_q;
            edge_d = '0;
        end
        if (w_wr && (w_off == OFF_EDGE)) begin
            edge_d = edge_d & ~write_data[WIDTH-1:0];
        end
        edge_d = edge_d | w_rise;

        mask_d = mask_q;
        if (w_wr && (w_off == OFF_MASK)) begin
            mask_d = write_data[WIDTH-1:0];
        end

`ifdef MMIO_FALL_EDGE_EN
        fall_d           = fall_q;
        fall_snap_d      = fall_snap_q;
        fall_rd_active_d = w_fall_rd;
        if (w_fall_rd && !fall_rd_active_q) begin
            fall_snap_d = fall_q;
            fall_d      = '0;
        end
        if (w_wr && (w_off == OFF_FALL)) begin
            fall_d = fall_d & ~write_data[WIDTH-1:0];
        end
        fall_d = fall_d | w_fall;
        irq_d  = |((edge_q | fall_q) & mask_q);
`else
        irq_d  = |(edge_q & mask_q);
`endif
    end

    always_comb begin
        read_data = 16'h0000;
        if (read_en) begin
            case (w_off)
                OFF_LEVEL: read_data = 16'(w_stable);
                OFF_EDGE:  read_data = 16'(rd_active_q ? snap_q : edge_q);
                OFF_MASK:  read_data = 16'(mask_q);
`ifdef MMIO_FALL_EDGE_EN
                OFF_FALL:  read_data = 16'(fall_rd_active_q ? fall_snap_q : fall_q);
`endif
                default:   read_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q      <= '0;
            snap_q      <= '0;
            mask_q      <= '0;
            rd_active_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            edge_q      <= edge_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            rd_active_q <= rd_active_d;
            irq_q       <= irq_d;
        end
    end

`ifdef MMIO_FALL_EDGE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fall_q           <= '0;
            fall_snap_q      <= '0;
            fall_rd_active_q <= 1'b0;
        end else begin
            fall_q           <= fall_d;
            fall_snap_q      <= fall_snap_d;
            fall_rd_active_q <= fall_rd_active_d;
        end
    end
`endif

    assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_input_port.sv
`default_nettype none
// Testbench for mmio_input_port: directed scenarios with literal expectations
// plus randomized bus/switch traffic checked every cycle against a model.
`timescale 1ns/1ps
module tb_mmio_input_port;

    localparam int         WIDTH = 10;
    localparam int         DB    = 4;
    localparam logic [8:0] BASE  = 9'h140;
`ifdef MMIO_FALL_EDGE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic [WIDTH-1:0] sw_raw     = '0;
    logic [1:0]       mem_cmd    = 2'b00;
    logic [8:0]       mem_addr   = '0;
    logic [15:0]      write_data = '0;
    logic [15:0]      read_data;
    logic             read_en;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    // Model state: raw sample history (index 0 newest) and register images.
    logic [WIDTH-1:0] hist [DB+2];
    logic [WIDTH-1:0] m_stable = '0, m_edge = '0, m_esnap = '0;
    logic [WIDTH-1:0] m_fall = '0, m_fsnap = '0, m_mask = '0;
    bit               m_eact = 0, m_fact = 0, m_irq = 0;

    always #5 clk = ~clk;

    mmio_input_port #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_en    (read_en),
        .irq        (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A level is accepted once the last DB synchronised samples (raw delayed
    // by two edges) all agree and differ from the current stable value.
    task automatic model_loop();
        logic [WIDTH-1:0] rise, fall, ne, nf;
        bit same, er, ew, fr, fw;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int k = 0; k < DB + 2; k++) hist[k] = '0;
                m_stable = '0; m_edge = '0; m_esnap = '0; m_fall = '0;
                m_fsnap = '0; m_mask = '0; m_eact = 0; m_fact = 0; m_irq = 0;
            end else begin
                for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = sw_raw;
                rise = '0;
                fall = '0;
                for (int b = 0; b < WIDTH; b++) begin
                    same = 1;
                    for (int k = 3; k <= DB + 1; k++) if (hist[k][b] != hist[2][b]) same = 0;
                    if (same && hist[2][b] != m_stable[b]) begin
                        if (hist[2][b]) rise[b] = 1'b1;
                        else            fall[b] = 1'b1;
                    end
                end
                m_irq = |((m_edge | m_fall) & m_mask);
                er = (mem_cmd == 2'b01) && (mem_addr == BASE + 9'd1);
                ew = (mem_cmd == 2'b10) && (mem_addr == BASE + 9'd1);
                fr = (mem_cmd == 2'b01) && (mem_addr == BASE + 9'd3) && FALL_EN;
                fw = (mem_cmd == 2'b10) && (mem_addr == BASE + 9'd3) && FALL_EN;
                ne = m_edge;
                if (er && !m_eact) begin m_esnap = m_edge; ne = '0; end
                if (ew) ne = ne & ~write_data[WIDTH-1:0];
                m_edge = ne | rise;
                if (FALL_EN) begin
                    nf = m_fall;
                    if (fr && !m_fact) begin m_fsnap = m_fall; nf = '0; end
                    if (fw) nf = nf & ~write_data[WIDTH-1:0];
                    m_fall = nf | fall;
                end
                if ((mem_cmd == 2'b10) && (mem_addr == BASE + 9'd2)) m_mask = write_data[WIDTH-1:0];
                m_stable = m_stable ^ (rise | fall);
                m_eact   = er;
                m_fact   = fr;
            end
        end
    endtask

    task automatic monitor_loop();
        int          off;
        logic        en;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            off = int'(mem_addr) - int'(BASE);
            en  = (mem_cmd == 2'b01) && (off >= 0) && ((off <= 2) || (off == 3 && FALL_EN));
            d   = 16'h0000;
            if (en) begin
                case (off)
                    0:       d = 16'(m_stable);
                    1:       d = 16'(m_eact ? m_esnap : m_edge);
                    2:       d = 16'(m_mask);
                    3:       d = 16'(m_fact ? m_fsnap : m_fall);
                    default: d = 16'h0000;
                endcase
            end
            check("mon_read_en", 32'(read_en), 32'(en));
            check("mon_read_data", 32'(read_data), 32'(d));
            check("mon_irq", 32'(irq), 32'(m_irq));
        end
    endtask

    task automatic setbus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input string nm, input logic [15:0] exp);
        @(negedge clk);
        check(nm, 32'(read_data), 32'(exp));
    endtask

    task automatic peek_irq(input string nm, input logic exp);
        @(negedge clk);
        check(nm, 32'(irq), 32'(exp));
    endtask

    // Number of edges after the current point until LEVEL first reads v.
    task automatic level_latency(input logic [15:0] v, output int first);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (first < 0 && read_data == v) first = i;
            step();
        end
    endtask

    task automatic driver();
        int          first;
        int          len;
        int          r;
        logic [1:0]  c;
        logic [8:0]  a;

        step(3);
        reset = 1'b1;
        setbus(2'b01, BASE, 16'h0);         peek("rst_level", 16'h0000); step();
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("rst_edge", 16'h0000);  step();
        setbus(2'b01, BASE + 9'd2, 16'h0);  peek("rst_mask", 16'h0000);
        check("rst_irq", 32'(irq), 32'd0);  step();

        // All switches high: level latency and captured edges.
        setbus(2'b01, BASE, 16'h0);
        sw_raw = 10'h3FF;
        level_latency(16'h03FF, first);
        check("level_latency", 32'(first), 32'd6);
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("edge_all", 16'h03FF); step();
        setbus(2'b00, 9'h0, 16'h0);         step();
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("edge_cleared", 16'h0000); step();
        setbus(2'b00, 9'h0, 16'h0);

        // Glitch shorter than the debounce window.
        sw_raw = 10'h3FE; step(10);
        sw_raw = 10'h3FF; step(3);
        sw_raw = 10'h3FE; step(10);
        setbus(2'b01, BASE, 16'h0);         peek("glitch_level", 16'h03FE); step();
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("glitch_edge", 16'h0000);  step();
        setbus(2'b00, 9'h0, 16'h0);

        // Held EDGE read returns the snapshot every cycle.
        sw_raw = 10'h3FA; step(10);
        sw_raw = 10'h3FF; step(10);
        setbus(2'b01, BASE + 9'd1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            peek("held_read", 16'h0005);
            step();
        end
        setbus(2'b00, 9'h0, 16'h0);         step();
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("after_held", 16'h0000); step();
        setbus(2'b00, 9'h0, 16'h0);         step();

        // New edge lands on the first EDGE-read cycle: set wins over clear.
        sw_raw = 10'h3FD; step(10);
        sw_raw = 10'h3FF; step(5);
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("coincident_old", 16'h0000); step();
        setbus(2'b00, 9'h0, 16'h0);         step();
        setbus(2'b01, BASE + 9'd1, 16'h0);  peek("coincident_new", 16'h0002); step();
        setbus(2'b00, 9'h0, 16'h0);         step();

        // Masked interrupt and W1C clear.
        setbus(2'b10, BASE + 9'd2, 16'h0002); step();
        setbus(2'b00, 9'h0, 16'h0);
        sw_raw = 10'h3FD; step(10);
        sw_raw = 10'h3FF;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (first < 0 && irq) first = i;
            step();
        end
        check("irq_latency", 32'(first), 32'd7);
        setbus(2'b10, BASE + 9'd1, 16'h0002); step();
        setbus(2'b00, 9'h0, 16'h0);
        peek_irq("irq_w1c_lag", 1'b1); step();
        peek_irq("irq_w1c_clear", 1'b0); step();

        // Reserved / falling-edge register.
        if (FALL_EN) begin
            setbus(2'b10, BASE + 9'd3, 16'h03FF); step();
            setbus(2'b00, 9'h0, 16'h0);
            sw_raw = 10'h3FB; step(10);
            setbus(2'b01, BASE + 9'd3, 16'h0); peek("fall_bit2", 16'h0004); step();
        end else begin
            sw_raw = 10'h3FB; step(10);
            setbus(2'b01, BASE + 9'd3, 16'h0); peek("reserved_data", 16'h0000);
            check("reserved_en", 32'(read_en), 32'd0); step();
        end
        setbus(2'b00, 9'h0, 16'h0);

        // Reset in the middle of a debounce discards the partial count.
        setbus(2'b01, BASE, 16'h0);
        sw_raw = 10'h000; step(3);
        #2 reset = 1'b0;
        sw_raw = 10'h3FF;
        peek("reset_async_level", 16'h0000);
        step(2);
        reset = 1'b1;
        level_latency(16'h03FF, first);
        check("reset_latency", 32'(first), 32'd6);

        // Randomized traffic, checked by the monitor every cycle.
        for (int n = 0; n < 300; n++) begin
            len = $urandom_range(1, 4);
            r   = $urandom_range(0, 9);
            c   = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'b00;
            a   = BASE - 9'd1 + 9'($urandom_range(0, 5));
            setbus(c, a, 16'($urandom));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, (n < 150) ? 1 : 7) == 0)
                    sw_raw = sw_raw ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                step();
            end
            if ($urandom_range(0, 2) == 0) begin
                setbus(2'b00, 9'h0, 16'h0);
                step();
            end
        end
        setbus(2'b00, 9'h0, 16'h0);
        step(2);
    endtask

    initial begin
        for (int k = 0; k < DB + 2; k++) hist[k] = '0;
        fork
            driver();
            model_loop();
            monitor_loop();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
